// File: rtl/load_unit_pkg.sv
// Shared definitions for the load unit: load type encodings, FSM states
// and legality/alignment helpers. Split states exist with LOAD_MISALIGN_SPLIT_EN.
package load_unit_pkg;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
`ifdef LOAD_MISALIGN_SPLIT_EN
  localparam logic [2:0] S_REQ2  = 3'd4;
  localparam logic [2:0] S_WAIT2 = 3'd5;
`endif

  function automatic logic ld_legal(input logic [2:0] t);
    logic ok;
    case (t)
      LD_LB, LD_LH, LD_LW,
      LD_LBU, LD_LHU: ok = 1'b1;
      default:        ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic ld_misaligned(
    input logic [2:0] t,
    input logic [1:0] off
  );
    logic mis;
    case (t)
      LD_LH, LD_LHU: mis = off[0];
      LD_LW:         mis = (off != 2'b00);
      default:       mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Byte/halfword/word extraction with sign or zero extension from a
// 64-bit window shifted down by the byte offset.
module load_extract
  import load_unit_pkg::*;
(
  input  logic [63:0] i_win,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_type,
  output logic [31:0] o_data
);

  logic [5:0]  w_sh;
  logic [31:0] w_lo;

  assign w_sh = {i_off, 3'b000};
  assign w_lo = i_win[w_sh +: 32];

  // select and extend the addressed field
  always_comb begin
    o_data = '0;
    case (i_type)
      LD_LB:  o_data = {{24{w_lo[7]}}, w_lo[7:0]};
      LD_LBU: o_data = {24'h0, w_lo[7:0]};
      LD_LH:  o_data = {{16{w_lo[15]}}, w_lo[15:0]};
      LD_LHU: o_data = {16'h0, w_lo[15:0]};
      LD_LW:  o_data = w_lo;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Load unit: word-aligned memory read, lane extraction, result handshake.
// Optional LOAD_MISALIGN_SPLIT_EN turns misaligned loads into two reads.
module load_unit
  import load_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [2:0]        ld_type,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic              res_err
);

  logic [2:0]  r_state;
  logic [2:0]  r_type;
  logic [1:0]  r_off;
  logic [63:0] w_win;
  logic [31:0] w_ext;
  logic        w_bad;
  logic        w_acc;
`ifdef LOAD_MISALIGN_SPLIT_EN
  logic [31:0] r_rdata1;
`endif

  assign ld_ready = (r_state == S_IDLE) && !rst;
  assign w_acc    = ld_valid && ld_ready;

`ifdef LOAD_MISALIGN_SPLIT_EN
  assign w_bad = !ld_legal(ld_type);
  assign w_win = (r_state == S_WAIT2) ?
                 {mem_rdata, r_rdata1} :
                 {32'h0, mem_rdata};
`else
  assign w_bad = !ld_legal(ld_type) ||
                 ld_misaligned(ld_type, ld_addr[1:0]);
  assign w_win = {32'h0, mem_rdata};
`endif

  load_extract u_extract (
    .i_win  (w_win),
    .i_off  (r_off),
    .i_type (r_type),
    .o_data (w_ext)
  );

  // control FSM and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_type        <= LD_LB;
      r_off         <= '0;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      res_valid     <= 1'b0;
      res_data      <= '0;
      res_err       <= 1'b0;
`ifdef LOAD_MISALIGN_SPLIT_EN
      r_rdata1      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_type <= ld_type;
            r_off  <= ld_addr[1:0];
            if (w_bad) begin
              res_valid <= 1'b1;
              res_err   <= 1'b1;
              res_data  <= '0;
              r_state   <= S_DONE;
            end else begin
              mem_req_valid <= 1'b1;
              mem_addr      <= {ld_addr[ADDR_W-1:2], 2'b00};
              r_state       <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            r_state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
`ifdef LOAD_MISALIGN_SPLIT_EN
            if (ld_misaligned(r_type, r_off)) begin
              r_rdata1      <= mem_rdata;
              mem_req_valid <= 1'b1;
              mem_addr      <= mem_addr + ADDR_W'(4);
              r_state       <= S_REQ2;
            end else
`endif
            begin
              res_valid <= 1'b1;
              res_err   <= 1'b0;
              res_data  <= w_ext;
              r_state   <= S_DONE;
            end
          end
        end
`ifdef LOAD_MISALIGN_SPLIT_EN
        S_REQ2: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            r_state       <= S_WAIT2;
          end
        end
        S_WAIT2: begin
          if (mem_rvalid) begin
            res_valid <= 1'b1;
            res_err   <= 1'b0;
            res_data  <= w_ext;
            r_state   <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit with a result scoreboard and a
// bench-driven memory responder.
module tb_load_unit;

`ifdef LOAD_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        ld_valid;
  logic        ld_ready;
  logic [2:0]  ld_type;
  logic [31:0] ld_addr;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_err;

  int n_pass;
  int n_total;

  logic [31:0] mem [logic [31:0]];
  logic [32:0] sb [$];

  load_unit #(.ADDR_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .ld_valid      (ld_valid),
    .ld_ready      (ld_ready),
    .ld_type       (ld_type),
    .ld_addr       (ld_addr),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .res_err       (res_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  function automatic bit is_legal(input logic [2:0] t);
    return (t == 3'd0) || (t == 3'd1) || (t == 3'd2) ||
           (t == 3'd4) || (t == 3'd5);
  endfunction

  function automatic bit is_mis(input logic [2:0] t, input logic [31:0] a);
    return ((t == 3'd1 || t == 3'd5) && a[0]) ||
           (t == 3'd2 && a[1:0] != 2'b00);
  endfunction

  // reference: {err, data}
  function automatic logic [32:0] ref_load(
    input logic [2:0]  t,
    input logic [31:0] a,
    input logic [31:0] w0,
    input logic [31:0] w1
  );
    logic [7:0]  b [8];
    logic [15:0] h;
    logic [31:0] w;
    int o;
    for (int i = 0; i < 4; i++) begin
      b[i]   = w0[8*i +: 8];
      b[i+4] = w1[8*i +: 8];
    end
    o = int'(a[1:0]);
    if (!is_legal(t) || (is_mis(t, a) && !SPLIT))
      return {1'b1, 32'h0};
    h = {b[o+1], b[o]};
    w = {b[o+3], b[o+2], b[o+1], b[o]};
    case (t)
      3'd0:    return {1'b0, {24{b[o][7]}}, b[o]};
      3'd4:    return {1'b0, 24'h0, b[o]};
      3'd1:    return {1'b0, {16{h[15]}}, h};
      3'd5:    return {17'h0, h};
      default: return {1'b0, w};
    endcase
  endfunction

  task automatic run_load(
    input logic [2:0]  t,
    input logic [31:0] a,
    input int          rq_stall,
    input int          rs_stall,
    input bit          chk_lat
  );
    logic [31:0] wa;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [32:0] exp_v;
    logic [32:0] got;
    int nw;
    int wt;
    bit nomem;
    wa = {a[31:2], 2'b00};
    w0 = rd_mem(wa);
    w1 = rd_mem(wa + 32'd4);
    if (!is_legal(t))       nw = 0;
    else if (!is_mis(t, a)) nw = 1;
    else                    nw = SPLIT ? 2 : 0;
    sb.push_back(ref_load(t, a, w0, w1));

    @(negedge clk);
    ld_valid = 1'b1;
    ld_type  = t;
    ld_addr  = a;
    n_total++;
    if (ld_ready !== 1'b1)
      $display("FAIL ld_ready_idle t=%0d a=%h got=%b want=1", t, a, ld_ready);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    ld_valid = 1'b0;
    ld_type  = 3'($urandom);
    ld_addr  = $urandom;

    for (int k = 0; k < nw; k++) begin
      wt = 0;
      while (mem_req_valid !== 1'b1 && wt < 20) begin
        @(negedge clk);
        wt++;
      end
      n_total++;
      if (mem_req_valid !== 1'b1)
        $display("FAIL req_timeout a=%h got=%b want=1", a, mem_req_valid);
      else n_pass++;
      if (chk_lat && k == 0) begin
        n_total++;
        if (wt != 0)
          $display("FAIL req_latency a=%h got=%0d want=0", a, wt);
        else n_pass++;
      end
      n_total++;
      if (mem_addr !== wa + 32'(4*k))
        $display("FAIL mem_addr a=%h got=%h want=%h", a, mem_addr, wa + 32'(4*k));
      else n_pass++;
      for (int s = 0; s < rq_stall; s++) begin
        mem_req_ready = 1'b0;
        @(negedge clk);
        n_total++;
        if (mem_req_valid !== 1'b1 || mem_addr !== wa + 32'(4*k) ||
            ld_ready !== 1'b0)
          $display("FAIL req_stable cyc=%0d got=%b/%h/%b want=1/%h/0",
                   s, mem_req_valid, mem_addr, ld_ready, wa + 32'(4*k));
        else n_pass++;
      end
      mem_req_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_rvalid    = 1'b1;
      mem_rdata     = (k == 0) ? w0 : w1;
      @(posedge clk);
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end

    wt    = 0;
    nomem = (mem_req_valid === 1'b0);
    while (res_valid !== 1'b1 && wt < 20) begin
      @(negedge clk);
      if (mem_req_valid !== 1'b0) nomem = 1'b0;
      wt++;
    end
    n_total++;
    if (res_valid !== 1'b1)
      $display("FAIL res_timeout a=%h got=%b want=1", a, res_valid);
    else n_pass++;
    if (nw == 0) begin
      n_total++;
      if (!nomem)
        $display("FAIL no_mem_access a=%h got=req want=none", a);
      else n_pass++;
    end
    if (chk_lat) begin
      n_total++;
      if (wt != 0)
        $display("FAIL res_latency a=%h got=%0d want=0", a, wt);
      else n_pass++;
    end

    got = {res_err, res_data};
    for (int s = 0; s < rs_stall; s++) begin
      res_ready = 1'b0;
      @(negedge clk);
      n_total++;
      if (res_valid !== 1'b1 || {res_err, res_data} !== got ||
          ld_ready !== 1'b0)
        $display("FAIL res_stable cyc=%0d got=%b/%h/%b want=1/%h/0",
                 s, res_valid, {res_err, res_data}, ld_ready, got);
      else n_pass++;
    end

    exp_v = sb.pop_front();
    n_total++;
    if ({res_err, res_data} !== exp_v)
      $display("FAIL result t=%0d a=%h got err=%b data=%h want err=%b data=%h",
               t, a, res_err, res_data, exp_v[32], exp_v[31:0]);
    else n_pass++;

    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    n_total++;
    if (res_valid !== 1'b0 || ld_ready !== 1'b1)
      $display("FAIL res_release got=%b/%b want=0/1", res_valid, ld_ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (ld_ready !== 1'b0 || mem_req_valid !== 1'b0 || mem_addr !== 32'h0 ||
        res_valid !== 1'b0 || res_data !== 32'h0 || res_err !== 1'b0)
      $display("FAIL reset_state got=%b%b %h %b %h %b want=00 0 0 0 0",
               ld_ready, mem_req_valid, mem_addr, res_valid, res_data, res_err);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_total++;
    if (ld_ready !== 1'b1)
      $display("FAIL ready_after_reset got=%b want=1", ld_ready);
    else n_pass++;
  endtask

  task automatic test_byte();
    run_load(3'd0, 32'h1003, 0, 0, 1'b1);
    run_load(3'd4, 32'h1003, 0, 0, 1'b1);
    run_load(3'd0, 32'h1001, 0, 0, 1'b0);
    run_load(3'd4, 32'h1000, 0, 0, 1'b0);
  endtask

  task automatic test_half();
    run_load(3'd1, 32'h2002, 0, 0, 1'b0);
    run_load(3'd5, 32'h2000, 0, 0, 1'b0);
    run_load(3'd1, 32'h2000, 0, 0, 1'b0);
    run_load(3'd2, 32'h2000, 0, 0, 1'b0);
  endtask

  task automatic test_misaligned();
    run_load(3'd2, 32'h3001, 0, 0, 1'b0);
    run_load(3'd1, 32'h3003, 0, 0, 1'b0);
    run_load(3'd5, 32'h3001, 0, 0, 1'b0);
  endtask

  task automatic test_stall();
    run_load(3'd5, 32'h2000, 5, 4, 1'b0);
  endtask

  task automatic test_illegal();
    run_load(3'd3, 32'h1000, 0, 2, 1'b0);
    run_load(3'd7, 32'h2000, 0, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int wt;
    @(negedge clk);
    ld_valid = 1'b1;
    ld_type  = 3'd2;
    ld_addr  = 32'h0;
    @(posedge clk);
    @(negedge clk);
    ld_valid = 1'b0;
    wt = 0;
    while (mem_req_valid !== 1'b1 && wt < 20) begin
      @(negedge clk);
      wt++;
    end
    n_total++;
    if (mem_req_valid !== 1'b1)
      $display("FAIL mid_req got=%b want=1", mem_req_valid);
    else n_pass++;
    mem_req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (res_valid !== 1'b0 || ld_ready !== 1'b1 || mem_req_valid !== 1'b0)
        $display("FAIL mid_reset_idle cyc=%0d got=%b%b%b want=010",
                 i, res_valid, ld_ready, mem_req_valid);
      else n_pass++;
      @(negedge clk);
    end
    run_load(3'd2, 32'h0, 0, 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [2:0]  types [5];
    logic [31:0] bases [4];
    logic [2:0]  t;
    logic [31:0] a;
    types = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    bases = '{32'h1000, 32'h2000, 32'h3000, 32'h4000};
    for (int i = 0; i < 16; i++) begin
      t = types[$urandom_range(0, 4)];
      a = bases[$urandom_range(0, 3)] + 32'($urandom_range(0, 3));
      run_load(t, a, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
    end
  endtask

  initial begin
    n_pass        = 0;
    n_total       = 0;
    rst           = 1'b1;
    ld_valid      = 1'b0;
    ld_type       = 3'd0;
    ld_addr       = 32'h0;
    mem_req_ready = 1'b0;
    mem_rvalid    = 1'b0;
    mem_rdata     = 32'h0;
    res_ready     = 1'b0;
    mem[32'h0000] = 32'hDEADBEEF;
    mem[32'h1000] = 32'h80AABBCC;
    mem[32'h1004] = 32'h0F1E2D3C;
    mem[32'h2000] = 32'h80017FFF;
    mem[32'h2004] = 32'hA5B6C7D8;
    mem[32'h3000] = 32'h44332211;
    mem[32'h3004] = 32'h88776655;
    mem[32'h4000] = 32'hF00DCAFE;
    mem[32'h4004] = 32'h13579BDF;

    test_reset();
    test_byte();
    test_half();
    test_misaligned();
    test_stall();
    test_illegal();
    test_reset_mid();
    test_back_to_back();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
